// File: rtl/jk_multimode_reg.sv
// WIDTH-bit register whose bits are JK-controlled or driven by whole-word load/shift/count modes; 1-cycle latency.
// No backpressure: En=0 freezes Q and Wrap; Tc, Zero, SerOut, Qbar are combinational from Q and Mode.
module jk_multimode_reg #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             SerOut,
    output logic             Tc,
    output logic             Zero,
    output logic             Wrap
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_JK     = 3'b001;
    localparam logic [2:0] MODE_LOAD   = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_SHR    = 3'b100;
    localparam logic [2:0] MODE_CNT_UP = 3'b101;
    localparam logic [2:0] MODE_CNT_DN = 3'b110;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] up_tgl;
    logic [WIDTH-1:0] dn_tgl;
    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic             tc;

    // Counter toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_tgl   = '0;
        dn_tgl   = '0;
        low_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_mask  = (WIDTH'(1) << i) - WIDTH'(1);
            up_tgl[i] = ((q_q & low_mask) == low_mask);
            dn_tgl[i] = ((q_q & low_mask) == '0);
        end
    end

    assign shl_val = {q_q[WIDTH-2:0], SerIn};
    assign shr_val = {SerIn, q_q[WIDTH-1:1]};

    // Every mode is expressed as per-bit J/K drive so a single JK update covers them all.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        case (Mode)
            MODE_JK: begin
                j_eff = J;
                k_eff = K;
            end
            MODE_LOAD: begin
                j_eff = D;
                k_eff = ~D;
            end
            MODE_SHL: begin
                j_eff = shl_val;
                k_eff = ~shl_val;
            end
            MODE_SHR: begin
                j_eff = shr_val;
                k_eff = ~shr_val;
            end
            MODE_CNT_UP: begin
                j_eff = up_tgl;
                k_eff = up_tgl;
            end
            MODE_CNT_DN: begin
                j_eff = dn_tgl;
                k_eff = dn_tgl;
            end
            default: begin
                j_eff = '0;
                k_eff = '0;
            end
        endcase
    end

    always_comb begin
        tc = 1'b0;
        if (Mode == MODE_CNT_UP) begin
            tc = (q_q == {WIDTH{1'b1}});
        end else if (Mode == MODE_CNT_DN) begin
            tc = (q_q == '0);
        end
    end

    always_comb begin
        q_d    = q_q;
        wrap_d = wrap_q;
        if (Clr) begin
            q_d    = '0;
            wrap_d = 1'b0;
        end else if (En) begin
            q_d = (j_eff & ~q_q) | (~k_eff & q_q);
            // LOAD never counts, so it wins over any wrap set.
            if (Mode == MODE_LOAD) begin
                wrap_d = 1'b0;
            end else if (tc) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        SerOut = 1'b0;
        if (Mode == MODE_SHL) begin
            SerOut = q_q[WIDTH-1];
        end else if (Mode == MODE_SHR) begin
            SerOut = q_q[0];
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;
    assign Tc   = tc;
    assign Zero = (q_q == '0);
    assign Wrap = wrap_q;

    // HOLD and the reserved encoding fall through the default JK drive (no change).
    logic unused_hold_ok;
    assign unused_hold_ok = (MODE_HOLD == 3'b000);

endmodule

// File: tb/tb_jk_multimode_reg.sv
// Directed table-driven bench for jk_multimode_reg (WIDTH=8, RESET_VALUE=8'hA5).
module tb_jk_multimode_reg;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_JK   = 3'b001;
    localparam logic [2:0] M_LOAD = 3'b010;
    localparam logic [2:0] M_SHL  = 3'b011;
    localparam logic [2:0] M_SHR  = 3'b100;
    localparam logic [2:0] M_UP   = 3'b101;
    localparam logic [2:0] M_DN   = 3'b110;
    localparam logic [2:0] M_RSVD = 3'b111;

    logic       Clk;
    logic       Reset;
    logic       Clr;
    logic       En;
    logic [2:0] Mode;
    logic [7:0] J;
    logic [7:0] K;
    logic [7:0] D;
    logic       SerIn;
    logic [7:0] Q;
    logic [7:0] Qbar;
    logic       SerOut;
    logic       Tc;
    logic       Zero;
    logic       Wrap;

    int checks = 0;
    int errors = 0;

    jk_multimode_reg #(
        .WIDTH      (8),
        .RESET_VALUE(8'hA5)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (Clr),
        .En    (En),
        .Mode  (Mode),
        .J     (J),
        .K     (K),
        .D     (D),
        .SerIn (SerIn),
        .Q     (Q),
        .Qbar  (Qbar),
        .SerOut(SerOut),
        .Tc    (Tc),
        .Zero  (Zero),
        .Wrap  (Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       clr;
        logic       en;
        logic [2:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic       serin;
        logic       pre_serout;
        logic       pre_tc;
        logic [7:0] exp_q;
        logic       exp_wrap;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic clr, input logic en, input logic [2:0] mode,
                                input logic [7:0] j, input logic [7:0] k, input logic [7:0] d,
                                input logic serin, input logic pso, input logic ptc,
                                input logic [7:0] eq, input logic ew);
        vec_t v;
        v.clr = clr; v.en = en; v.mode = mode; v.j = j; v.k = k; v.d = d;
        v.serin = serin; v.pre_serout = pso; v.pre_tc = ptc; v.exp_q = eq; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic en, input logic [2:0] mode,
                         input logic [7:0] d);
        Clr = clr; En = en; Mode = mode; D = d; J = 8'h00; K = 8'h00; SerIn = 1'b0;
    endtask

    initial begin
        //          clr en mode    J      K      D      si pso ptc  expQ   wrap
        vq.push_back(mk(0, 1, M_LOAD, 8'h00, 8'h00, 8'h3C, 0, 0, 0, 8'h3C, 0));
        vq.push_back(mk(0, 1, M_LOAD, 8'h00, 8'h00, 8'hF0, 0, 0, 0, 8'hF0, 0));
        vq.push_back(mk(0, 1, M_JK,   8'h0F, 8'h3C, 8'h00, 0, 0, 0, 8'hCF, 0));
        vq.push_back(mk(0, 1, M_LOAD, 8'h00, 8'h00, 8'h81, 0, 0, 0, 8'h81, 0));
        vq.push_back(mk(0, 1, M_SHL,  8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h02, 0));
        vq.push_back(mk(0, 1, M_SHR,  8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h81, 0));
        vq.push_back(mk(0, 1, M_LOAD, 8'h00, 8'h00, 8'hFE, 0, 0, 0, 8'hFE, 0));
        vq.push_back(mk(0, 1, M_UP,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 0));
        vq.push_back(mk(0, 1, M_UP,   8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h00, 1));
        vq.push_back(mk(0, 1, M_UP,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h01, 1));
        vq.push_back(mk(0, 1, M_HOLD, 8'hFF, 8'hFF, 8'hAA, 1, 0, 0, 8'h01, 1));
        vq.push_back(mk(0, 1, M_LOAD, 8'h00, 8'h00, 8'h01, 0, 0, 0, 8'h01, 0));
        vq.push_back(mk(0, 1, M_DN,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 0, M_DN,   8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h00, 0));
        vq.push_back(mk(0, 0, M_DN,   8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h00, 0));
        vq.push_back(mk(0, 1, M_DN,   8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hFF, 1));
        vq.push_back(mk(0, 1, M_JK,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 1));
        vq.push_back(mk(0, 1, M_SHL,  8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hFE, 1));
        vq.push_back(mk(1, 0, M_LOAD, 8'h00, 8'h00, 8'h55, 0, 0, 0, 8'h00, 0));
        vq.push_back(mk(0, 1, M_LOAD, 8'h00, 8'h00, 8'h5A, 0, 0, 0, 8'h5A, 0));
        vq.push_back(mk(0, 1, M_RSVD, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 8'h5A, 0));
        vq.push_back(mk(0, 1, M_JK,   8'hFF, 8'hFF, 8'h00, 0, 0, 0, 8'hA5, 0));
        vq.push_back(mk(0, 1, M_DN,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hA4, 0));
        vq.push_back(mk(0, 1, M_UP,   8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hA5, 0));
        vq.push_back(mk(0, 1, M_SHR,  8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h52, 0));
        vq.push_back(mk(0, 1, M_SHL,  8'h00, 8'h00, 8'h00, 1, 0, 0, 8'hA5, 0));

        // Power-on reset, checked while Reset is still high and before any edge.
        Reset = 1'b1;
        drive(0, 0, M_HOLD, 8'h00);
        #2;
        check("reset_q", Q, 8'hA5);
        check("reset_qbar", Qbar, 8'h5A);
        check("reset_wrap", {7'b0, Wrap}, 8'h00);
        check("reset_zero", {7'b0, Zero}, 8'h00);
        #2 Reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge Clk);
            Clr = vq[i].clr; En = vq[i].en; Mode = vq[i].mode;
            J = vq[i].j; K = vq[i].k; D = vq[i].d; SerIn = vq[i].serin;
            #1;
            check($sformatf("v%0d_pre_serout", i), {7'b0, SerOut}, {7'b0, vq[i].pre_serout});
            check($sformatf("v%0d_pre_tc", i), {7'b0, Tc}, {7'b0, vq[i].pre_tc});
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_q", i), Q, vq[i].exp_q);
            check($sformatf("v%0d_qbar", i), Qbar, ~vq[i].exp_q);
            check($sformatf("v%0d_wrap", i), {7'b0, Wrap}, {7'b0, vq[i].exp_wrap});
            check($sformatf("v%0d_zero", i), {7'b0, Zero}, {7'b0, (vq[i].exp_q == 8'h00)});
        end

        // Wrap up from FF, then hit async Reset between edges.
        @(negedge Clk);
        drive(0, 1, M_LOAD, 8'hFF);
        @(posedge Clk);
        @(negedge Clk);
        drive(0, 1, M_UP, 8'h00);
        @(posedge Clk);
        #1;
        check("seq_wrap_q", Q, 8'h00);
        check("seq_wrap_set", {7'b0, Wrap}, 8'h01);
        @(negedge Clk);
        drive(0, 1, M_HOLD, 8'h00);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_q", Q, 8'hA5);
        check("async_reset_qbar", Qbar, 8'h5A);
        check("async_reset_wrap", {7'b0, Wrap}, 8'h00);
        #1 Reset = 1'b0;
        drive(0, 1, M_LOAD, 8'h3C);
        @(posedge Clk);
        #1;
        check("post_reset_load", Q, 8'h3C);
        check("post_reset_wrap", {7'b0, Wrap}, 8'h00);

        // Clr wins over an enabled count at terminal value.
        @(negedge Clk);
        drive(0, 1, M_LOAD, 8'hFF);
        @(posedge Clk);
        @(negedge Clk);
        drive(1, 1, M_UP, 8'h00);
        #1;
        check("clr_pre_tc", {7'b0, Tc}, 8'h01);
        @(posedge Clk);
        #1;
        check("clr_over_count_q", Q, 8'h00);
        check("clr_over_count_wrap", {7'b0, Wrap}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
